// File: rtl/fwd_pkg.sv
// Shared definitions for the operand-forwarding stage.
//   fwd_sel_t : 2-bit per-channel operand source select
//   SEL_REG   : operand comes from the held register-file value (or zero for r0)
//   SEL_WB    : operand forwarded from the write-back stage
//   SEL_MEM   : operand forwarded from the MEM stage
// The encoding 2'b11 is reserved and never produced.
package fwd_pkg;

    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t SEL_REG = 2'b00;
    localparam fwd_sel_t SEL_WB  = 2'b01;
    localparam fwd_sel_t SEL_MEM = 2'b10;

endpackage

// File: rtl/fwd_operand_stage_if.sv
// Bundle of the ID-side handshake, the MEM/WB bypass buses and the EX-side
// handshake of the operand-forwarding stage.
//   slave  : the forwarding stage's own view
//   master : the surrounding pipeline's view (ID, MEM, WB and EX stages)
// Flat vectors carry channel i at [i*REGW +: REGW], [i*WIDTH +: WIDTH]
// and [i*2 +: 2].
interface fwd_operand_stage_if #(
    parameter int WIDTH = 32,
    parameter int NSRC  = 2,
    parameter int REGW  = 5
);
    // ID side
    logic                    id_valid;
    logic                    id_ready;
    logic [NSRC*REGW-1:0]    id_rs;
    logic [NSRC*WIDTH-1:0]   id_rdata;

    // MEM-stage bypass
    logic                    mem_wen;
    logic                    mem_is_load;
    logic [REGW-1:0]         mem_rd;
    logic [WIDTH-1:0]        mem_data;

    // WB-stage bypass
    logic                    wb_wen;
    logic [REGW-1:0]         wb_rd;
    logic [WIDTH-1:0]        wb_data;

    // EX side
    logic                    ex_valid;
    logic                    ex_ready;
    logic [NSRC*WIDTH-1:0]   ex_op;
    logic [NSRC*2-1:0]       ex_sel;

    modport slave (
        input  id_valid, id_rs, id_rdata,
        input  mem_wen, mem_is_load, mem_rd, mem_data,
        input  wb_wen, wb_rd, wb_data,
        input  ex_ready,
        output id_ready, ex_valid, ex_op, ex_sel
    );

    modport master (
        output id_valid, id_rs, id_rdata,
        output mem_wen, mem_is_load, mem_rd, mem_data,
        output wb_wen, wb_rd, wb_data,
        output ex_ready,
        input  id_ready, ex_valid, ex_op, ex_sel
    );

endinterface

// File: rtl/fwd_match.sv
// Single-channel forwarding resolver: compares one held source register
// against the MEM and WB destinations and picks the operand by priority
// (r0, MEM, WB, held value). Purely combinational.
//   rs, rd_val          : held source register and its buffered value
//   mem_*, wb_*         : bypass buses from the later pipeline stages
//   op, sel             : resolved operand and its source select
//   blocked             : MEM holds a load whose data is not yet available
module fwd_match
    import fwd_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int REGW  = 5
) (
    input  logic [REGW-1:0]  rs,
    input  logic [WIDTH-1:0] rd_val,
    input  logic             mem_wen,
    input  logic             mem_is_load,
    input  logic [REGW-1:0]  mem_rd,
    input  logic [WIDTH-1:0] mem_data,
    input  logic             wb_wen,
    input  logic [REGW-1:0]  wb_rd,
    input  logic [WIDTH-1:0] wb_data,
    output logic [WIDTH-1:0] op,
    output fwd_sel_t         sel,
    output logic             blocked
);

    always_comb begin
        op      = rd_val;
        sel     = SEL_REG;
        blocked = 1'b0;
        if (rs == '0) begin
            // r0 is hard-wired to zero and must never pick up a bypass value
            op = '0;
        end else if (mem_wen && (mem_rd == rs)) begin
            op      = mem_data;
            sel     = SEL_MEM;
            blocked = mem_is_load;
        end else if (wb_wen && (wb_rd == rs)) begin
            op  = wb_data;
            sel = SEL_WB;
        end
    end

endmodule

// File: rtl/fwd_operand_stage.sv
// ID/EX operand-forwarding stage. Holds one issued instruction's source
// registers and buffered operand values, resolves each channel every cycle
// against the MEM and WB bypasses, stalls on load-use hazards and hands the
// operands to EX over a valid/ready handshake.
//   clk, rst  : clock, synchronous active-high reset (wins over flush)
//   flush     : drop the held instruction and suppress a same-cycle capture
//   stall_cnt : saturating count of cycles spent blocked on a load
//   bus       : ID handshake, MEM/WB bypass buses, EX handshake (slave view)
module fwd_operand_stage
    import fwd_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NSRC  = 2,
    parameter int REGW  = 5,
    parameter int CNTW  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    output logic [CNTW-1:0]   stall_cnt,
    fwd_operand_stage_if.slave bus
);

    logic            hv_reg;
    logic            hv_next;
    logic [CNTW-1:0] stall_cnt_reg;
    logic [NSRC-1:0] ch_blocked;
    logic            blocked;
    logic            ex_valid;
    logic            id_ready;
    logic            capture;
    logic            transfer;

    assign blocked  = hv_reg && (|ch_blocked);
    assign ex_valid = hv_reg && !blocked;
    assign transfer = ex_valid && bus.ex_ready;
    assign id_ready = !hv_reg || transfer;
    assign capture  = bus.id_valid && id_ready && !flush;

    assign bus.ex_valid = ex_valid;
    assign bus.id_ready = id_ready;
    assign stall_cnt    = stall_cnt_reg;

    generate
        for (genvar gi = 0; gi < NSRC; gi++) begin : g_ch
            logic [REGW-1:0]  rs_reg;
            logic [WIDTH-1:0] rd_val_reg;
            logic [REGW-1:0]  id_rs_ch;
            logic [WIDTH-1:0] id_rdata_ch;
            logic [WIDTH-1:0] ch_op;
            fwd_sel_t         ch_sel;
            logic             wb_hit_id;
            logic             wb_hit_held;

            assign id_rs_ch    = bus.id_rs[gi*REGW +: REGW];
            assign id_rdata_ch = bus.id_rdata[gi*WIDTH +: WIDTH];

            // The register file may be written in the very cycle it is read;
            // write-through makes the captured value reflect that write.
            assign wb_hit_id   = bus.wb_wen && (bus.wb_rd == id_rs_ch) && (id_rs_ch != '0);
            // Write-backs landing while we wait are folded into the buffer so
            // a value forwarded earlier survives after WB retires.
            assign wb_hit_held = bus.wb_wen && (bus.wb_rd == rs_reg) && (rs_reg != '0);

            always_ff @(posedge clk) begin
                if (rst) begin
                    rs_reg     <= '0;
                    rd_val_reg <= '0;
                end else if (capture) begin
                    rs_reg     <= id_rs_ch;
                    rd_val_reg <= wb_hit_id ? bus.wb_data : id_rdata_ch;
                end else if (hv_reg && wb_hit_held) begin
                    rd_val_reg <= bus.wb_data;
                end
            end

            fwd_match #(
                .WIDTH (WIDTH),
                .REGW  (REGW)
            ) u_match (
                .rs          (rs_reg),
                .rd_val      (rd_val_reg),
                .mem_wen     (bus.mem_wen),
                .mem_is_load (bus.mem_is_load),
                .mem_rd      (bus.mem_rd),
                .mem_data    (bus.mem_data),
                .wb_wen      (bus.wb_wen),
                .wb_rd       (bus.wb_rd),
                .wb_data     (bus.wb_data),
                .op          (ch_op),
                .sel         (ch_sel),
                .blocked     (ch_blocked[gi])
            );

            assign bus.ex_op[gi*WIDTH +: WIDTH] = ch_op;
            assign bus.ex_sel[gi*2 +: 2]        = ch_sel;
        end
    endgenerate

    // A capture in the same cycle as a transfer keeps the stage full.
    always_comb begin
        hv_next = hv_reg;
        if (flush) begin
            hv_next = 1'b0;
        end else if (capture) begin
            hv_next = 1'b1;
        end else if (transfer) begin
            hv_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hv_reg        <= 1'b0;
            stall_cnt_reg <= '0;
        end else begin
            hv_reg <= hv_next;
            if (blocked && (stall_cnt_reg != '1)) begin
                stall_cnt_reg <= stall_cnt_reg + CNTW'(1);
            end
        end
    end

endmodule
